// File: rtl/popcount_pkg.sv
// Shared definitions for popcount_arbiter.
//   state_t : controller FSM states (IDLE, BUSY, HOLD)
//   id_w()  : width of a requester index for a given requester count
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // A single requester still needs one bit of id.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_population_counter.sv
// Registered population counter: counts ones in data_i and presents the
// result one cycle after data_val_i.
//   clk_i      : clock
//   srst_i     : synchronous reset, active-high
//   data_i     : WIDTH-bit word
//   data_val_i : data_i is valid this cycle
//   data_o     : count of ones, 0..WIDTH
//   data_val_o : data_o is valid (one cycle after data_val_i)
module bit_population_counter #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic [CNT_W-1:0] data_o,
  output logic             data_val_o
);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + CNT_W'(data_i[i]);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_o     <= '0;
      data_val_o <= 1'b0;
    end else begin
      data_val_o <= data_val_i;
      if (data_val_i) data_o <= cnt;
    end
  end

endmodule

// File: rtl/popcount_arbiter.sv
// Round-robin front end sharing one bit_population_counter among REQ_NUM
// requesters. One word in flight at a time: IDLE grants, BUSY captures the
// count, HOLD presents it until the downstream accepts.
//   clk_i, rst_i  : clock, async active-high reset
//   req_data_i    : per-requester words, index k = requester k
//   req_val_i     : per-requester valid
//   req_ready_o   : one-hot (or zero) grant, combinational in IDLE
//   data_o        : population count of the granted word
//   data_id_o     : index of the requester owning data_o
//   data_val_o    : result valid
//   data_ready_i  : downstream accepts the result
// Build option: POPCOUNT_ARBITER_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin; the pointer is removed.
module popcount_arbiter
  import popcount_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REQ_NUM = 4,
  localparam int CNT_W  = $clog2(WIDTH) + 1,
  localparam int ID_W   = id_w(REQ_NUM)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [REQ_NUM-1:0][WIDTH-1:0]   req_data_i,
  input  logic [REQ_NUM-1:0]              req_val_i,
  output logic [REQ_NUM-1:0]              req_ready_o,
  output logic [CNT_W-1:0]                data_o,
  output logic [ID_W-1:0]                 data_id_o,
  output logic                            data_val_o,
  input  logic                            data_ready_i
);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  gnt_id, id_q;
  logic             any_val, hs;
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_val;

  // ---------------- pick ----------------
`ifdef POPCOUNT_ARBITER_FIXED_PRIO_EN
  always_comb begin
    any_val = 1'b0;
    gnt_id  = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (req_val_i[i]) begin
        any_val = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;

  // Search starts at ptr and wraps; first asserted request wins.
  always_comb begin
    int idx;
    any_val = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = (int'(ptr) + i) % REQ_NUM;
      if (!any_val && req_val_i[idx]) begin
        any_val = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)   ptr <= '0;
    else if (hs) ptr <= (gnt_id == ID_W'(REQ_NUM - 1)) ? '0 : gnt_id + 1'b1;
  end
`endif

  // Ready is masked during reset so nothing is accepted while rst_i is high.
  assign hs = (state == IDLE) && any_val && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[gnt_id] = 1'b1;
  end

  // ---------------- shared counter ----------------
  bit_population_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk_i      (clk_i),
    .srst_i     (rst_i),
    .data_i     (req_data_i[gnt_id]),
    .data_val_i (hs),
    .data_o     (cnt_data),
    .data_val_o (cnt_val)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs)           state_nxt = BUSY;
      BUSY:    if (cnt_val)      state_nxt = HOLD;
      HOLD:    if (data_ready_i) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // ---------------- result registers ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q       <= '0;
      data_o     <= '0;
      data_id_o  <= '0;
      data_val_o <= 1'b0;
    end else begin
      if (hs) id_q <= gnt_id;
      if (state == BUSY && cnt_val) begin
        data_o     <= cnt_data;
        data_id_o  <= id_q;
        data_val_o <= 1'b1;
      end else if (state == HOLD && data_ready_i) begin
        data_val_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_arbiter.sv
// Scoreboard bench for popcount_arbiter: the check process predicts each
// grant from a transaction-level model and queues the expected result; the
// monitor compares every presented result against the queue head.
module tb_popcount_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]        req_val, req_ready;
  logic [4:0]          data;
  logic [1:0]          data_id;
  logic                data_val, data_ready;

  popcount_arbiter #(.WIDTH(W), .REQ_NUM(N)) dut (
    .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_val_i(req_val),
    .req_ready_o(req_ready), .data_o(data), .data_id_o(data_id),
    .data_val_o(data_val), .data_ready_i(data_ready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int cnt; int hcyc; } item_t;
  item_t sbq[$];
  int    glog[$];

  logic [N-1:0] pend = '0, sticky = '0;
  logic [W-1:0] word [N];
  int  mptr = 0;
  bit  rnd_en = 0, drdy_rnd = 0, seen = 0;

  function automatic int pop_ref(input logic [W-1:0] w);
    int c = 0;
    for (int i = 0; i < W; i++) if (w[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus, applied on the falling edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (rnd_en) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1; word[k] = W'($urandom);
        end else if (pend[k] && $urandom_range(0, 15) == 0) begin
          pend[k] = 1'b0;   // withdrawn before grant: never counted
        end
      end
      if (sticky[k] && !pend[k]) begin pend[k] = 1'b1; word[k] = W'($urandom); end
    end
    if (drdy_rnd) data_ready = ($urandom_range(0, 9) < 7);
    req_val = pend;
    for (int k = 0; k < N; k++) req_data[k] = pend[k] ? word[k] : W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend != '0 || sbq.size() != 0) && n < 300) begin step(); n++; end
    if (n >= 300) chk("drain_timeout", n, 0);
    step(); step();
  endtask

  task automatic wait_val();
    int n = 0;
    while (data_val !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) chk("val_timeout", n, 0);
  endtask

  task automatic chk_order(input string name, input int exp_o[$]);
    chk({name, "_len"}, glog.size(), exp_o.size());
    for (int i = 0; i < exp_o.size() && i < glog.size(); i++)
      chk(name, glog[i], exp_o[i]);
  endtask

  // Grant checker / scoreboard producer.
  initial forever begin
    logic [N-1:0] er;
    int g, k;
    @(negedge clk); #1;
    er = '0; g = -1; k = 0;
    if (rst !== 1'b1 && sbq.size() == 0) begin
      for (int i = 0; i < N; i++) begin
`ifdef POPCOUNT_ARBITER_FIXED_PRIO_EN
        k = i;
`else
        k = (mptr + i) % N;
`endif
        if (g < 0 && req_val[k]) g = k;
      end
      if (g >= 0) er[g] = 1'b1;
    end
    chk("req_ready", int'(req_ready), int'(er));
    if (g >= 0) begin
      sbq.push_back('{id: g, cnt: pop_ref(req_data[g]), hcyc: cyc});
      glog.push_back(g);
      pend[g] = 1'b0;
      mptr = (g + 1) % N;
    end
  end

  // Result monitor / scoreboard consumer.
  initial forever begin
    @(negedge clk); #2;
    if (data_val !== 1'b0) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_result: got id=%0d data=%0d expected no result", data_id, data);
      end else begin
        if (!seen) begin chk("latency", cyc - sbq[0].hcyc, 2); seen = 1; end
        chk("data", int'(data), sbq[0].cnt);
        chk("data_id", int'(data_id), sbq[0].id);
        if (data_ready) begin void'(sbq.pop_front()); seen = 0; end
      end
    end
  end

  initial begin
    int g3;
    rst = 1'b1; data_ready = 1'b1; req_val = '0; req_data = '0;
    for (int k = 0; k < N; k++) word[k] = '0;
    #1;
    chk("rst_val", int'(data_val), 0);
    chk("rst_ready", int'(req_ready), 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // single request, popcount 8
    pend[2] = 1'b1; word[2] = 16'hF00F;
    wait_idle();
    chk("f00f_count", pop_ref(16'hF00F) == 8 ? 8 : -1, 8);

    // boundaries
    pend[0] = 1'b1; word[0] = 16'h0000; wait_idle();
    pend[3] = 1'b1; word[3] = 16'hFFFF; wait_idle();

    // reset while a result is held
    data_ready = 1'b0;
    pend[1] = 1'b1; word[1] = 16'h1234;
    wait_val();
    step();
    #3 rst = 1'b1;
    #1;
    chk("midrst_val", int'(data_val), 0);
    chk("midrst_data", int'(data), 0);
    chk("midrst_id", int'(data_id), 0);
    chk("midrst_ready", int'(req_ready), 0);
    sbq.delete(); seen = 0; mptr = 0; pend = '0;
    step(); step();
    rst = 1'b0; data_ready = 1'b1;
    repeat (6) step();

    // round-robin: all four valid, each drops after its grant
    glog.delete();
    for (int k = 0; k < N; k++) word[k] = W'($urandom);
    pend = '1;
    wait_idle();
    chk_order("rr_burst1", '{0, 1, 2, 3});
    pend[0] = 1'b1; word[0] = 16'h00FF; wait_idle();
    glog.delete();
    pend = 4'b1001; word[0] = 16'h0F0F; word[3] = 16'h0001;
    wait_idle();
`ifdef POPCOUNT_ARBITER_FIXED_PRIO_EN
    chk_order("rr_burst2", '{0, 3});
`else
    chk_order("rr_burst2", '{3, 0});
`endif

    // backpressure: result held 5 cycles, another requester waiting
    data_ready = 1'b0;
    pend[1] = 1'b1; word[1] = 16'hA5A5;
    wait_val();
    pend[2] = 1'b1; word[2] = 16'h8001;
    repeat (5) step();
    data_ready = 1'b1;
    wait_idle();

    // requesters 0 and 3 continuously valid
    glog.delete();
    sticky = 4'b1001;
    repeat (30) step();
    sticky = '0;
    wait_idle();
    g3 = 0;
    foreach (glog[i]) if (glog[i] == 3) g3++;
`ifdef POPCOUNT_ARBITER_FIXED_PRIO_EN
    chk("starve_grants3", g3, 0);
`else
    chk("alt_grants3", int'(g3 > 0), 1);
`endif

    // random traffic with random backpressure
    rnd_en = 1; drdy_rnd = 1;
    repeat (2000) step();
    rnd_en = 0; drdy_rnd = 0; data_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
